// File: rtl/mod_counter_prog.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter_prog
// Brief    : Runtime-programmable modulo counter with up/down, clear, load,
//            wrap/one-shot modes and registered wrap/halted status.
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter_prog #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned FINAL_VALUE = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_value,
    input  logic             up_down,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] final_q,
    output logic             at_term,
    output logic             wrap,
    output logic             halted
);

    localparam logic [WIDTH-1:0] c_final_rst = FINAL_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_zero      = '0;
    localparam logic [WIDTH-1:0] c_one       = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_final;
    logic             r_wrap;
    logic             r_halted;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic             w_halted_nxt;
    logic [WIDTH-1:0] w_eff_final;
    logic [WIDTH-1:0] w_terminal;

    // A load in the same cycle as mod_wr clamps against the value being written
    assign w_eff_final = mod_wr ? mod_value : r_final;
    assign w_terminal  = up_down ? r_final : c_zero;

    always_comb begin
        w_q_nxt      = r_q;
        w_wrap_nxt   = 1'b0;
        w_halted_nxt = r_halted && oneshot;
        if (clear) begin
            w_q_nxt      = c_zero;
            w_halted_nxt = 1'b0;
        end else if (load) begin
            w_q_nxt      = (load_value > w_eff_final) ? w_eff_final : load_value;
            w_halted_nxt = 1'b0;
        end else if (enable && !r_halted) begin
            if (up_down) begin
                if (r_q >= r_final) begin
                    w_q_nxt    = c_zero;
                    w_wrap_nxt = 1'b1;
                end else if (oneshot && (r_q == r_final - c_one)) begin
                    w_q_nxt      = r_final;
                    w_wrap_nxt   = 1'b1;
                    w_halted_nxt = 1'b1;
                end else begin
                    w_q_nxt = r_q + c_one;
                end
            end else begin
                if ((r_q == c_zero) || (r_q > r_final)) begin
                    w_q_nxt    = r_final;
                    w_wrap_nxt = 1'b1;
                end else if (oneshot && (r_q == c_one)) begin
                    w_q_nxt      = c_zero;
                    w_wrap_nxt   = 1'b1;
                    w_halted_nxt = 1'b1;
                end else begin
                    w_q_nxt = r_q - c_one;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q      <= c_zero;
            r_final  <= c_final_rst;
            r_wrap   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_q      <= w_q_nxt;
            r_wrap   <= w_wrap_nxt;
            r_halted <= w_halted_nxt;
            if (mod_wr) begin
                r_final <= mod_value;
            end
        end
    end

    assign q       = r_q;
    assign final_q = r_final;
    assign wrap    = r_wrap;
    assign halted  = r_halted;
    assign at_term = (r_q == w_terminal);

endmodule
`default_nettype wire

// File: tb/tb_mod_counter_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_counter_prog
// Brief    : Scoreboard bench for mod_counter_prog with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_counter_prog;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       clear;
    logic       load;
    logic [7:0] load_value;
    logic       mod_wr;
    logic [7:0] mod_value;
    logic       up_down;
    logic       oneshot;
    logic [7:0] q;
    logic [7:0] final_q;
    logic       at_term;
    logic       wrap;
    logic       halted;

    typedef struct {
        logic [7:0] q;
        logic       w;
        logic       h;
        logic       t;
        logic [7:0] f;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mod_counter_prog #(.WIDTH(8), .FINAL_VALUE(9)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .load(load), .load_value(load_value), .mod_wr(mod_wr),
        .mod_value(mod_value), .up_down(up_down), .oneshot(oneshot),
        .q(q), .final_q(final_q), .at_term(at_term), .wrap(wrap),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one registered response per driven cycle, sampled after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q",       32'(q),       32'(e.q));
                chk("wrap",    32'(wrap),    32'(e.w));
                chk("halted",  32'(halted),  32'(e.h));
                chk("at_term", 32'(at_term), 32'(e.t));
                chk("final_q", 32'(final_q), 32'(e.f));
            end
        end
    end

    task automatic cyc(input logic [7:0] eq, input logic ew, input logic eh,
                       input logic et, input logic [7:0] ef);
        exp_t e;
        e.q = eq; e.w = ew; e.h = eh; e.t = et; e.f = ef;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        enable = 0; clear = 0; load = 0; load_value = 0;
        mod_wr = 0; mod_value = 0; oneshot = 0;
    endtask

    initial begin
        int guard;
        reset_n = 0;
        up_down = 1;
        idle_inputs();
        #12;
        chk("rst_q",      32'(q),       32'd0);
        chk("rst_final",  32'(final_q), 32'd9);
        chk("rst_wrap",   32'(wrap),    32'd0);
        chk("rst_halted", 32'(halted),  32'd0);
        chk("rst_term",   32'(at_term), 32'd0);
        @(negedge clk);
        reset_n = 1;

        // Free run up 0..9,0
        enable = 1;
        for (int i = 1; i <= 9; i++) cyc(8'(i), 0, 0, (i == 9), 9);
        cyc(0, 1, 0, 0, 9);

        // Load wins over enable, then count down through wrap to final
        up_down = 0; load = 1; load_value = 5;
        cyc(5, 0, 0, 0, 9);
        load = 0;
        cyc(4, 0, 0, 0, 9);
        cyc(3, 0, 0, 0, 9);
        cyc(2, 0, 0, 0, 9);
        cyc(1, 0, 0, 0, 9);
        cyc(0, 0, 0, 1, 9);
        cyc(9, 1, 0, 0, 9);
        cyc(8, 0, 0, 0, 9);
        enable = 0; load = 1; load_value = 12;
        cyc(9, 0, 0, 0, 9);

        // Modulus shrink with simultaneous step
        up_down = 1; load_value = 7;
        cyc(7, 0, 0, 0, 9);
        load = 0; enable = 1; mod_wr = 1; mod_value = 3;
        cyc(8, 0, 0, 0, 3);
        mod_wr = 0;
        cyc(0, 1, 0, 0, 3);
        cyc(1, 0, 0, 0, 3);
        cyc(2, 0, 0, 0, 3);
        cyc(3, 0, 0, 1, 3);
        cyc(0, 1, 0, 0, 3);

        // Load clamps against a same-cycle modulus write
        enable = 0; load = 1; load_value = 9; mod_wr = 1; mod_value = 4;
        cyc(4, 0, 0, 1, 4);
        load = 0; mod_wr = 0; clear = 1; enable = 1;
        cyc(0, 0, 0, 0, 4);
        clear = 0;

        // One-shot up to 4
        oneshot = 1;
        cyc(1, 0, 0, 0, 4);
        cyc(2, 0, 0, 0, 4);
        cyc(3, 0, 0, 0, 4);
        cyc(4, 1, 1, 1, 4);
        cyc(4, 0, 1, 1, 4);
        cyc(4, 0, 1, 1, 4);
        oneshot = 0;
        cyc(4, 0, 0, 1, 4);
        cyc(0, 1, 0, 0, 4);
        oneshot = 1;
        cyc(1, 0, 0, 0, 4);
        cyc(2, 0, 0, 0, 4);
        cyc(3, 0, 0, 0, 4);
        cyc(4, 1, 1, 1, 4);
        enable = 0; clear = 1;
        cyc(0, 0, 0, 0, 4);
        clear = 0; oneshot = 0;

        // clear beats load and enable
        enable = 1;
        cyc(1, 0, 0, 0, 4);
        clear = 1; load = 1; load_value = 2;
        cyc(0, 0, 0, 0, 4);
        clear = 0; load = 0;

        // final_q = 0: pinned at 0, wrap every enabled cycle
        enable = 0; mod_wr = 1; mod_value = 0;
        cyc(0, 0, 0, 1, 0);
        mod_wr = 0; enable = 1;
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);

        // Async reset mid-count after a modulus write
        enable = 0; load = 1; load_value = 6; mod_wr = 1; mod_value = 12;
        cyc(6, 0, 0, 0, 12);
        idle_inputs();
        #2;
        reset_n = 0;
        #1;
        chk("arst_q",      32'(q),       32'd0);
        chk("arst_final",  32'(final_q), 32'd9);
        chk("arst_wrap",   32'(wrap),    32'd0);
        chk("arst_halted", 32'(halted),  32'd0);
        @(negedge clk);
        reset_n = 1;
        cyc(0, 0, 0, 0, 9);
        enable = 1;
        cyc(1, 0, 0, 0, 9);
        cyc(2, 0, 0, 0, 9);
        enable = 0;

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
